// File: rtl/chroma_corner_pkg.sv
// chroma_corner_pkg
// Shared definitions for the chroma corner tracker: parameter defaults,
// the frame state encoding, accumulator clear values and the helper that
// locates a channel's slice inside a flattened per-channel bus.
package chroma_corner_pkg;

  localparam int NUM_CH_DEFAULT  = 4;
  localparam int COORD_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Per-bit clear values, replicated to the field width at the point of use:
  // count clears to 0, min fields to all-ones, max fields to 0.
  localparam logic ACC_CNT_CLR = 1'b0;
  localparam logic ACC_MIN_CLR = 1'b1;
  localparam logic ACC_MAX_CLR = 1'b0;

  // LSB position of channel ch inside a bus of width-bit fields.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/corner_bbox_accum.sv
// corner_bbox_accum
// Per-channel frame accumulator: saturating match count plus bounding box.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   hit              registered per-pixel match for this channel
//   load             accumulation enabled this cycle
//   clear            restart the frame; a hit in the same cycle is counted
//                    on top of the cleared values (first pixel of a frame)
//   x, y             registered pixel coordinates
//   count            saturating match count
//   x_min .. y_max   bounding box of matched pixels
module corner_bbox_accum
  import chroma_corner_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int CNT_W   = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hit,
  input  logic               load,
  input  logic               clear,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [CNT_W-1:0]   count,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max
);

  logic [CNT_W-1:0]   cnt_base;
  logic [COORD_W-1:0] x_min_base, x_max_base, y_min_base, y_max_base;

  always_comb begin
    cnt_base   = clear ? {CNT_W{ACC_CNT_CLR}}   : count;
    x_min_base = clear ? {COORD_W{ACC_MIN_CLR}} : x_min;
    x_max_base = clear ? {COORD_W{ACC_MAX_CLR}} : x_max;
    y_min_base = clear ? {COORD_W{ACC_MIN_CLR}} : y_min;
    y_max_base = clear ? {COORD_W{ACC_MAX_CLR}} : y_max;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{ACC_CNT_CLR}};
      x_min <= {COORD_W{ACC_MIN_CLR}};
      x_max <= {COORD_W{ACC_MAX_CLR}};
      y_min <= {COORD_W{ACC_MIN_CLR}};
      y_max <= {COORD_W{ACC_MAX_CLR}};
    end else begin
      count <= cnt_base;
      x_min <= x_min_base;
      x_max <= x_max_base;
      y_min <= y_min_base;
      y_max <= y_max_base;
      if (hit && load) begin
        if (cnt_base != '1) count <= cnt_base + CNT_W'(1);
        if (x < x_min_base) x_min <= x;
        if (x > x_max_base) x_max <= x;
        if (y < y_min_base) y_min <= y;
        if (y > y_max_base) y_max <= y;
      end
    end
  end

endmodule

// File: rtl/chroma_corner_tracker.sv
// chroma_corner_tracker
// Classifies each YCbCr pixel against NUM_CH inclusive Cb/Cr windows and
// publishes a per-channel match count, found flag and bounding box once
// per frame.
// Ports:
//   clk, reset                   pixel clock, synchronous active-high reset
//   pix_valid, sof, eof          pixel qualifier and frame markers
//   pix_x, pix_y, Cb, Cr         current pixel
//   cb_lo..cr_hi                 window bounds, channel k at [8k+7:8k]
//   match, match_valid           registered per-pixel classification
//   res_valid                    one-cycle pulse when results update
//   found, count, x_min..y_max   results of the last complete frame
//
// state  | meaning
// IDLE   | results held, accumulators idle; registered sof starts a frame
// ACCUM  | accumulating; eof -> REPORT, sof restarts the frame in place
// REPORT | one cycle: publish accumulators, pulse res_valid, clear
module chroma_corner_tracker
  import chroma_corner_pkg::*;
#(
  parameter int          NUM_CH     = NUM_CH_DEFAULT,
  parameter int          COORD_W    = COORD_W_DEFAULT,
  parameter int          CNT_W      = 19,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic                      sof,
  input  logic                      eof,
  input  logic [COORD_W-1:0]        pix_x,
  input  logic [COORD_W-1:0]        pix_y,
  input  logic [7:0]                Cb,
  input  logic [7:0]                Cr,
  input  logic [8*NUM_CH-1:0]       cb_lo,
  input  logic [8*NUM_CH-1:0]       cb_hi,
  input  logic [8*NUM_CH-1:0]       cr_lo,
  input  logic [8*NUM_CH-1:0]       cr_hi,
  output logic [NUM_CH-1:0]         match,
  output logic                      match_valid,
  output logic                      res_valid,
  output logic [NUM_CH-1:0]         found,
  output logic [CNT_W*NUM_CH-1:0]   count,
  output logic [COORD_W*NUM_CH-1:0] x_min,
  output logic [COORD_W*NUM_CH-1:0] x_max,
  output logic [COORD_W*NUM_CH-1:0] y_min,
  output logic [COORD_W*NUM_CH-1:0] y_max
);

  logic [NUM_CH-1:0]  hit_c;
  logic [COORD_W-1:0] pix_x_r, pix_y_r;
  logic               sof_r, eof_r;

  // An inverted window (lo > hi) fails one of the two compares for every
  // value, so it never matches without any special casing.
  always_comb begin
    hit_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit_c[k] = pix_valid
               && (Cb >= cb_lo[ch_lsb(k, 8) +: 8]) && (Cb <= cb_hi[ch_lsb(k, 8) +: 8])
               && (Cr >= cr_lo[ch_lsb(k, 8) +: 8]) && (Cr <= cr_hi[ch_lsb(k, 8) +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match       <= '0;
      match_valid <= 1'b0;
      pix_x_r     <= '0;
      pix_y_r     <= '0;
      sof_r       <= 1'b0;
      eof_r       <= 1'b0;
    end else begin
      match       <= hit_c;
      match_valid <= pix_valid;
      pix_x_r     <= pix_x;
      pix_y_r     <= pix_y;
      sof_r       <= sof;
      eof_r       <= eof;
    end
  end

  state_t state_q, state_d;
  logic   acc_load, acc_clear, publish;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // eof wins over a coincident sof. A sof arriving in the REPORT cycle
  // opens the next frame directly so back-to-back frames are not lost.
  always_comb begin
    state_d   = state_q;
    acc_load  = 1'b0;
    acc_clear = 1'b0;
    publish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof_r && !eof_r) begin
          state_d   = ACCUM;
          acc_clear = 1'b1;
          acc_load  = 1'b1;
        end
      end
      ACCUM: begin
        acc_load = 1'b1;
        if (eof_r)      state_d   = REPORT;
        else if (sof_r) acc_clear = 1'b1;
      end
      REPORT: begin
        publish   = 1'b1;
        acc_clear = 1'b1;
        if (sof_r && !eof_r) begin
          state_d  = ACCUM;
          acc_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [CNT_W-1:0]   acc_cnt   [NUM_CH];
  logic [COORD_W-1:0] acc_x_min [NUM_CH];
  logic [COORD_W-1:0] acc_x_max [NUM_CH];
  logic [COORD_W-1:0] acc_y_min [NUM_CH];
  logic [COORD_W-1:0] acc_y_max [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    corner_bbox_accum #(
      .COORD_W (COORD_W),
      .CNT_W   (CNT_W)
    ) u_accum (
      .clk   (clk),
      .reset (reset),
      .hit   (match[k]),
      .load  (acc_load),
      .clear (acc_clear),
      .x     (pix_x_r),
      .y     (pix_y_r),
      .count (acc_cnt[k]),
      .x_min (acc_x_min[k]),
      .x_max (acc_x_max[k]),
      .y_min (acc_y_min[k]),
      .y_max (acc_y_max[k])
    );
  end

  logic [NUM_CH-1:0] ch_found;

  always_comb begin
    ch_found = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_found[k] = (32'(acc_cnt[k]) >= MIN_PIXELS);
    end
  end

  // Channels below the threshold publish a zero box so downstream corner
  // logic never sees the all-ones min values of an empty accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      found     <= '0;
      count     <= '0;
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
    end else begin
      res_valid <= publish;
      if (publish) begin
        for (int k = 0; k < NUM_CH; k++) begin
          found[k]                              <= ch_found[k];
          count[ch_lsb(k, CNT_W) +: CNT_W]      <= acc_cnt[k];
          x_min[ch_lsb(k, COORD_W) +: COORD_W]  <= ch_found[k] ? acc_x_min[k] : '0;
          x_max[ch_lsb(k, COORD_W) +: COORD_W]  <= ch_found[k] ? acc_x_max[k] : '0;
          y_min[ch_lsb(k, COORD_W) +: COORD_W]  <= ch_found[k] ? acc_y_min[k] : '0;
          y_max[ch_lsb(k, COORD_W) +: COORD_W]  <= ch_found[k] ? acc_y_max[k] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chroma_corner_tracker.sv
// Bench for chroma_corner_tracker: two instances share one stimulus stream,
// one with a wide counter (CNT_W=19, MIN_PIXELS=16) and one narrow enough
// to saturate (CNT_W=4, MIN_PIXELS=4). A frame-level model keeps the list
// of matched pixels of the open frame and derives counts/boxes at eof.
module tb_chroma_corner_tracker;

  localparam int NCH  = 2;
  localparam int CW   = 10;
  localparam int CNTA = 19;
  localparam int MINA = 16;
  localparam int CNTB = 4;
  localparam int MINB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, pix_valid, sof, eof;
  logic [CW-1:0]       pix_x, pix_y;
  logic [7:0]          Cb, Cr;
  logic [8*NCH-1:0]    cb_lo, cb_hi, cr_lo, cr_hi;

  logic [NCH-1:0]      match_a, found_a, match_b, found_b;
  logic                mv_a, rv_a, mv_b, rv_b;
  logic [CNTA*NCH-1:0] count_a;
  logic [CNTB*NCH-1:0] count_b;
  logic [CW*NCH-1:0]   xmn_a, xmx_a, ymn_a, ymx_a;
  logic [CW*NCH-1:0]   xmn_b, xmx_b, ymn_b, ymx_b;

  chroma_corner_tracker #(.NUM_CH(NCH), .COORD_W(CW), .CNT_W(CNTA), .MIN_PIXELS(MINA)) dut_a (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .sof(sof), .eof(eof),
    .pix_x(pix_x), .pix_y(pix_y), .Cb(Cb), .Cr(Cr),
    .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
    .match(match_a), .match_valid(mv_a), .res_valid(rv_a), .found(found_a), .count(count_a),
    .x_min(xmn_a), .x_max(xmx_a), .y_min(ymn_a), .y_max(ymx_a));

  chroma_corner_tracker #(.NUM_CH(NCH), .COORD_W(CW), .CNT_W(CNTB), .MIN_PIXELS(MINB)) dut_b (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .sof(sof), .eof(eof),
    .pix_x(pix_x), .pix_y(pix_y), .Cb(Cb), .Cr(Cr),
    .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
    .match(match_b), .match_valid(mv_b), .res_valid(rv_b), .found(found_b), .count(count_b),
    .x_min(xmn_b), .x_max(xmx_b), .y_min(ymn_b), .y_max(ymx_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct {
    int             x;
    int             y;
    logic [NCH-1:0] hit;
  } pix_t;

  pix_t frame_q[$];
  bit   in_frame = 0;
  int   n_pub[NCH];
  int   bx_pub[NCH][4];   // xmin, xmax, ymin, ymax
  int   n_pend[NCH];
  int   bx_pend[NCH][4];
  int   cyc = 0;
  int   due = -1;

  function automatic logic [NCH-1:0] classify();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) begin
      r[k] = pix_valid && (Cb >= cb_lo[k*8 +: 8]) && (Cb <= cb_hi[k*8 +: 8])
                       && (Cr >= cr_lo[k*8 +: 8]) && (Cr <= cr_hi[k*8 +: 8]);
    end
    return r;
  endfunction

  function automatic void add_pix(input logic [NCH-1:0] h);
    pix_t p;
    if (h != '0) begin
      p.x = int'(pix_x); p.y = int'(pix_y); p.hit = h;
      frame_q.push_back(p);
    end
  endfunction

  function automatic void summarize();
    for (int k = 0; k < NCH; k++) begin
      n_pend[k] = 0;
      bx_pend[k][0] = 1023; bx_pend[k][1] = 0; bx_pend[k][2] = 1023; bx_pend[k][3] = 0;
    end
    foreach (frame_q[i]) begin
      for (int k = 0; k < NCH; k++) begin
        if (frame_q[i].hit[k]) begin
          n_pend[k]++;
          if (frame_q[i].x < bx_pend[k][0]) bx_pend[k][0] = frame_q[i].x;
          if (frame_q[i].x > bx_pend[k][1]) bx_pend[k][1] = frame_q[i].x;
          if (frame_q[i].y < bx_pend[k][2]) bx_pend[k][2] = frame_q[i].y;
          if (frame_q[i].y > bx_pend[k][3]) bx_pend[k][3] = frame_q[i].y;
        end
      end
    end
  endfunction

  task automatic chk_pub(input string tag, input int cw, input int mn, input logic [NCH-1:0] f,
                         input logic [63:0] c, input logic [CW*NCH-1:0] xa, input logic [CW*NCH-1:0] xb,
                         input logic [CW*NCH-1:0] ya, input logic [CW*NCH-1:0] yb);
    for (int k = 0; k < NCH; k++) begin
      int sat;
      bit ef;
      sat = (n_pub[k] > (1 << cw) - 1) ? (1 << cw) - 1 : n_pub[k];
      ef  = (sat >= mn);
      chk($sformatf("%s_found%0d", tag, k), 64'(f[k]), 64'(ef));
      chk($sformatf("%s_count%0d", tag, k), (c >> (k*cw)) & ((64'd1 << cw) - 1), 64'(sat));
      chk($sformatf("%s_xmin%0d", tag, k), 64'(xa[k*CW +: CW]), ef ? 64'(bx_pub[k][0]) : 64'd0);
      chk($sformatf("%s_xmax%0d", tag, k), 64'(xb[k*CW +: CW]), ef ? 64'(bx_pub[k][1]) : 64'd0);
      chk($sformatf("%s_ymin%0d", tag, k), 64'(ya[k*CW +: CW]), ef ? 64'(bx_pub[k][2]) : 64'd0);
      chk($sformatf("%s_ymax%0d", tag, k), 64'(yb[k*CW +: CW]), ef ? 64'(bx_pub[k][3]) : 64'd0);
    end
  endtask

  // One clock: update the model from the driven inputs, clock, then check.
  task automatic step();
    logic [NCH-1:0] em;
    logic           emv;
    bit             due_next;
    due_next = 0;
    if (reset) begin
      in_frame = 0;
      frame_q.delete();
      due = -1;
      for (int k = 0; k < NCH; k++) begin
        n_pub[k] = 0;
        for (int j = 0; j < 4; j++) bx_pub[k][j] = 0;
      end
      em = '0; emv = 1'b0;
    end else begin
      emv = pix_valid;
      em  = classify();
      if (eof && in_frame) begin
        add_pix(em); summarize(); due_next = 1; in_frame = 0;
      end else if (sof && !eof) begin
        frame_q.delete(); in_frame = 1; add_pix(em);
      end else if (in_frame) begin
        add_pix(em);
      end
    end
    @(posedge clk); #1;
    cyc++;
    chk("match_valid_a", 64'(mv_a), 64'(emv));
    chk("match_valid_b", 64'(mv_b), 64'(emv));
    chk("match_a", 64'(match_a), 64'(em));
    chk("match_b", 64'(match_b), 64'(em));
    chk("res_valid_a", 64'(rv_a), 64'(cyc == due));
    chk("res_valid_b", 64'(rv_b), 64'(cyc == due));
    if (cyc == due) begin
      n_pub  = n_pend;
      bx_pub = bx_pend;
    end
    if (due_next) due = cyc + 2;
    chk_pub("a", CNTA, MINA, found_a, 64'(count_a), xmn_a, xmx_a, ymn_a, ymx_a);
    chk_pub("b", CNTB, MINB, found_b, 64'(count_b), xmn_b, xmx_b, ymn_b, ymx_b);
  endtask

  task automatic drive(input bit v, input int x, input int y, input int cb, input int cr,
                       input bit s, input bit e);
    pix_valid = v; pix_x = CW'(x); pix_y = CW'(y); Cb = 8'(cb); Cr = 8'(cr); sof = s; eof = e;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_win(input int k, input int cbl, input int cbh, input int crl, input int crh);
    cb_lo[k*8 +: 8] = 8'(cbl); cb_hi[k*8 +: 8] = 8'(cbh);
    cr_lo[k*8 +: 8] = 8'(crl); cr_hi[k*8 +: 8] = 8'(crh);
  endtask

  // ---------------- classification vectors ----------------
  typedef struct {
    bit v;
    int cb, cr, cbl, cbh, crl, crh;
    bit exp0;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wl[NCH][4];

    vecs[0]  = '{1,  40,  60,  40,  90,  40,  90, 1};   // Cb at lo
    vecs[1]  = '{1,  91,  60,  40,  90,  40,  90, 0};   // Cb at hi+1
    vecs[2]  = '{1,  90,  90,  40,  90,  40,  90, 1};   // both at hi
    vecs[3]  = '{1,  39,  60,  40,  90,  40,  90, 0};   // Cb at lo-1
    vecs[4]  = '{1,  60,  91,  40,  90,  40,  90, 0};   // Cr at hi+1
    vecs[5]  = '{1,  60,  40,  40,  90,  40,  90, 1};   // Cr at lo
    vecs[6]  = '{0,  60,  60,  40,  90,  40,  90, 0};   // not valid
    vecs[7]  = '{1,  77,  77,  77,  77,  77,  77, 1};   // single-value window
    vecs[8]  = '{1,  60,  60, 100,  50,   0, 255, 0};   // Cb lo > hi
    vecs[9]  = '{1, 255,   0, 200, 255,   0,  10, 1};   // extremes
    vecs[10] = '{1,   0, 255,   0,  10, 200, 255, 1};
    vecs[11] = '{1,  60,  60,  40,  90,  90,  40, 0};   // Cr lo > hi

    reset = 1; pix_valid = 0; sof = 0; eof = 0; pix_x = '0; pix_y = '0; Cb = '0; Cr = '0;
    cb_lo = '0; cb_hi = '0; cr_lo = '0; cr_hi = '0;
    set_win(1, 100, 50, 0, 255);
    idle(3);
    chk("rst_res_valid", 64'(rv_a), 64'd0);
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_xmin", 64'(xmn_a), 64'd0);
    reset = 0;
    idle(2);

    // Pixel-level window boundaries, one cycle latency each.
    for (int i = 0; i < 12; i++) begin
      set_win(0, vecs[i].cbl, vecs[i].cbh, vecs[i].crl, vecs[i].crh);
      drive(vecs[i].v, i, i, vecs[i].cb, vecs[i].cr, 0, 0);
      chk($sformatf("vec%0d_match0", i), 64'(match_a[0]), 64'(vecs[i].exp0));
      chk($sformatf("vec%0d_match1", i), 64'(match_a[1]), 64'd0);
    end
    idle(2);

    // Two channels, two patches.
    set_win(0, 0, 60, 0, 60);
    set_win(1, 200, 255, 200, 255);
    drive(1, 0, 0, 128, 128, 1, 0);
    drive(0, 1, 0, 30, 30, 0, 0);
    drive(1, 300, 200, 128, 30, 0, 0);
    for (int y = 50; y < 70; y++)
      for (int x = 100; x < 120; x++) drive(1, x, y, 30, 30, 0, 0);
    drive(0, 5, 5, 220, 220, 0, 0);
    for (int y = 470; y < 480; y++)
      for (int x = 600; x < 610; x++) drive(1, x, y, 220, 220, 0, 0);
    drive(1, 639, 479, 128, 128, 0, 1);
    idle(1);
    chk("t2_rv_early", 64'(rv_a), 64'd0);
    idle(1);
    chk("t2_rv", 64'(rv_a), 64'd1);
    chk("t2_found", 64'(found_a), 64'd3);
    chk("t2_cnt0", 64'(count_a[18:0]), 64'd400);
    chk("t2_cnt1", 64'(count_a[37:19]), 64'd100);
    chk("t2_box0", {xmn_a[9:0], xmx_a[9:0], ymn_a[9:0], ymx_a[9:0]}, {10'd100, 10'd119, 10'd50, 10'd69});
    chk("t2_box1", {xmn_a[19:10], xmx_a[19:10], ymn_a[19:10], ymx_a[19:10]}, {10'd600, 10'd609, 10'd470, 10'd479});
    idle(3);

    // Below MIN_PIXELS: 3x3 patch.
    drive(1, 0, 0, 128, 128, 1, 0);
    for (int y = 20; y < 23; y++)
      for (int x = 10; x < 13; x++) drive(1, x, y, 30, 30, 0, 0);
    drive(1, 0, 0, 128, 128, 0, 1);
    idle(2);
    chk("t3_cnt0", 64'(count_a[18:0]), 64'd9);
    chk("t3_found0", 64'(found_a[0]), 64'd0);
    chk("t3_xmax0", 64'(xmx_a[9:0]), 64'd0);
    chk("t3_found0_b", 64'(found_b[0]), 64'd1);
    idle(2);

    // Inverted ch0 window: no matches all frame.
    set_win(0, 100, 50, 0, 255);
    drive(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 64; i++) drive(1, i, 1, i * 4, i * 4, 0, 0);
    drive(1, 1, 1, 75, 75, 0, 1);
    idle(2);
    chk("t4_cnt0", 64'(count_a[18:0]), 64'd0);
    idle(2);
    set_win(0, 0, 60, 0, 60);

    // sof and eof each carrying a matching pixel.
    drive(1, 5, 5, 30, 30, 1, 0);
    idle(3);
    drive(1, 7, 9, 30, 30, 0, 1);
    idle(2);
    chk("t5_cnt_sof_eof", 64'(count_a[18:0]), 64'd2);
    idle(2);

    // sof and eof together in ACCUM: eof wins, pixel counted, no clear.
    drive(1, 0, 0, 128, 128, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, i, 4, 30, 30, 0, 0);
    drive(1, 8, 8, 30, 30, 1, 1);
    idle(2);
    chk("t5_cnt_both", 64'(count_a[18:0]), 64'd6);
    idle(2);

    // eof in IDLE is ignored.
    drive(1, 3, 3, 30, 30, 0, 1);
    idle(4);

    // sof mid-ACCUM discards the partial frame.
    drive(1, 0, 0, 128, 128, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, i, 1, 30, 30, 0, 0);
    drive(1, 50, 2, 30, 30, 1, 0);
    for (int i = 0; i < 19; i++) drive(1, i, 3, 30, 30, 0, 0);
    drive(1, 0, 0, 128, 128, 0, 1);
    idle(2);
    chk("t5_restart_cnt", 64'(count_a[18:0]), 64'd20);
    chk("t5_restart_box", {xmn_a[9:0], xmx_a[9:0], ymn_a[9:0], ymx_a[9:0]}, {10'd0, 10'd50, 10'd2, 10'd3});
    idle(2);

    // Reset mid-frame after 200 matches.
    drive(1, 0, 0, 128, 128, 1, 0);
    for (int i = 0; i < 200; i++) drive(1, i % 20, i / 20, 30, 30, 0, 0);
    reset = 1;
    idle(1);
    reset = 0;
    chk("t6_rst_count", 64'(count_a), 64'd0);
    chk("t6_rst_found", 64'(found_a), 64'd0);
    chk("t6_rst_xmax", 64'(xmx_a), 64'd0);
    for (int i = 0; i < 5; i++) drive(1, i, 7, 30, 30, 0, 0);
    drive(1, 9, 9, 30, 30, 0, 1);
    idle(3);
    drive(1, 0, 0, 128, 128, 1, 0);
    for (int i = 0; i < 25; i++) drive(1, 40 + i, 60, 30, 30, 0, 0);
    drive(1, 0, 0, 128, 128, 0, 1);
    idle(20);
    chk("t6_held_cnt", 64'(count_a[18:0]), 64'd25);
    chk("t6_held_found", 64'(found_a[0]), 64'd1);

    // Saturation on the narrow-counter instance.
    drive(1, 0, 0, 128, 128, 1, 0);
    for (int i = 0; i < 20; i++) drive(1, i, 11, 30, 30, 0, 0);
    drive(1, 0, 0, 128, 128, 0, 1);
    idle(2);
    chk("t7_sat_b", 64'(count_b[3:0]), 64'd15);
    chk("t7_sat_found_b", 64'(found_b[0]), 64'd1);
    chk("t7_wide_a", 64'(count_a[18:0]), 64'd20);
    idle(2);

    // Randomized frames against the model.
    for (int f = 0; f < 14; f++) begin
      int n;
      for (int k = 0; k < NCH; k++) begin
        int lo, hi, t;
        for (int a = 0; a < 2; a++) begin
          lo = $urandom_range(0, 200);
          hi = lo + $urandom_range(0, 80);
          if (hi > 255) hi = 255;
          if ($urandom_range(0, 9) == 0) begin t = lo; lo = hi; hi = t; end
          wl[k][2*a] = lo; wl[k][2*a+1] = hi;
        end
        set_win(k, wl[k][0], wl[k][1], wl[k][2], wl[k][3]);
      end
      drive(1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 255),
            $urandom_range(0, 255), 1, 0);
      n = $urandom_range(10, 120);
      for (int i = 0; i < n; i++) begin
        int ch, cb, cr;
        cb = $urandom_range(0, 255);
        cr = $urandom_range(0, 255);
        if ($urandom_range(0, 1) == 1) begin
          ch = $urandom_range(0, NCH - 1);
          if (wl[ch][0] <= wl[ch][1]) cb = $urandom_range(wl[ch][0], wl[ch][1]);
          if (wl[ch][2] <= wl[ch][3]) cr = $urandom_range(wl[ch][2], wl[ch][3]);
        end
        drive($urandom_range(0, 4) != 0, $urandom_range(0, 1023), $urandom_range(0, 1023),
              cb, cr, $urandom_range(0, 60) == 0, i == n - 1);
      end
      for (int g = 0; g < int'($urandom_range(3, 7)); g++)
        drive($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 255), $urandom_range(0, 255), 0, $urandom_range(0, 4) == 0);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
